// File: rtl/qoi_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : qoi_frame_ctrl
// Purpose  : Frame controller for a streaming QOI encoder. It accepts a frame
//            request, steers pixels from a ready/valid source into an
//            external encoder core, gathers the encoder's variable-length
//            chunks in a small FIFO, and serializes them to a byte stream.
//            With QOI_CTRL_HEADER_EN defined, the stream is wrapped in the
//            14-byte QOI header and the 8-byte end marker.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            start, width, height     - frame request (accepted in IDLE)
//            busy, done               - status, done is a one-cycle pulse
//            px_r/g/b/a, px_valid,
//            px_ready                 - pixel source handshake
//            enc_r/g/b/a, enc_en,
//            enc_rst                  - encoder pixel feed and control
//            enc_chunk, enc_chunk_bytes - registered encoder chunk (MSB first)
//            out_data, out_valid,
//            out_ready, out_last      - output byte stream
// Config   : QOI_CTRL_HEADER_EN       - emit QOI header and end marker
// Revision : 1.0 - initial release
// ============================================================================
module qoi_frame_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] width,
    input  logic [15:0] height,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  px_r,
    input  logic [7:0]  px_g,
    input  logic [7:0]  px_b,
    input  logic [7:0]  px_a,
    input  logic        px_valid,
    output logic        px_ready,
    output logic [7:0]  enc_r,
    output logic [7:0]  enc_g,
    output logic [7:0]  enc_b,
    output logic [7:0]  enc_a,
    output logic        enc_en,
    output logic        enc_rst,
    input  logic [31:0] enc_chunk,
    input  logic [2:0]  enc_chunk_bytes,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam int             c_AW    = $clog2(FIFO_DEPTH);
    // Highest occupancy at which a new encoder enable may be issued. Each
    // enable produces at most one push one cycle later, so two slots of
    // margin guarantee the FIFO never overflows.
    localparam logic [c_AW:0]  c_ROOM  = (c_AW+1)'(FIFO_DEPTH - 2);

    localparam logic [2:0]     c_IDLE  = 3'd0;
    localparam logic [2:0]     c_PIX   = 3'd2;
    localparam logic [2:0]     c_FLUSH = 3'd3;
`ifdef QOI_CTRL_HEADER_EN
    localparam logic [2:0]     c_HDR   = 3'd1;
    localparam logic [2:0]     c_TAIL  = 3'd4;
`endif

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic             w_done_set;
    logic             r_done;
    logic [31:0]      r_npix;          // pixels still to be consumed
    logic [31:0]      r_last_px;       // most recent pixel {r,g,b,a}
    logic             r_first;         // next enable is enable 0
    logic             r_en_d;          // an enable happened last cycle
    logic             r_en_first_d;    // ... and it was enable 0
    logic             r_flush_sent;

    logic [34:0]      r_fifo_mem [FIFO_DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic [34:0]      w_head;

    logic [31:0]      r_ser_data;
    logic [2:0]       r_ser_cnt;       // bytes left in the serializer

    logic [31:0]      w_n;
    logic             w_start;
    logic             w_room;
    logic             w_fifo_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_ser_active;
    logic             w_ser_valid;
    logic             w_ser_fire;
    logic             w_consume;
    logic             w_flush_en;

`ifdef QOI_CTRL_HEADER_EN
    logic [15:0]      r_width;
    logic [15:0]      r_height;
    logic [3:0]       r_idx;           // byte index within header / tail
    logic [7:0]       w_hdr_byte;
`endif

    assign w_n          = 32'(width) * 32'(height);
    assign w_start      = (r_state == c_IDLE) && start && !rst;
    assign w_room       = (r_count <= c_ROOM);
    assign w_fifo_empty = (r_count == '0);
    // The chunk presented the cycle after an enable belongs to the previous
    // pixel; the one following enable 0 has no owner and is dropped.
    assign w_push       = r_en_d && !r_en_first_d && (enc_chunk_bytes != 3'd0);
    assign w_head       = r_fifo_mem[r_rptr];
    assign w_ser_active = (r_state == c_PIX) || (r_state == c_FLUSH);
    assign w_ser_valid  = w_ser_active && (r_ser_cnt != 3'd0);
    assign w_ser_fire   = w_ser_valid && out_ready;
    // Reload as the last byte of the current chunk leaves so chunks stream
    // back to back.
    assign w_pop        = w_ser_active && !w_fifo_empty &&
                          ((r_ser_cnt == 3'd0) || ((r_ser_cnt == 3'd1) && out_ready));
    assign w_consume    = (r_state == c_PIX) && px_valid && w_room && !rst;
    assign w_flush_en   = (r_state == c_FLUSH) && !r_flush_sent && w_room && !rst;

    assign px_ready = w_consume;
    assign enc_en   = w_consume || w_flush_en;
    assign enc_rst  = w_start;
    assign busy     = (r_state != c_IDLE);
    assign done     = r_done;

`ifdef QOI_CTRL_HEADER_EN
    always_comb begin
        case (r_idx)
            4'd0:    w_hdr_byte = 8'h71;
            4'd1:    w_hdr_byte = 8'h6F;
            4'd2:    w_hdr_byte = 8'h69;
            4'd3:    w_hdr_byte = 8'h66;
            4'd6:    w_hdr_byte = r_width[15:8];
            4'd7:    w_hdr_byte = r_width[7:0];
            4'd10:   w_hdr_byte = r_height[15:8];
            4'd11:   w_hdr_byte = r_height[7:0];
            4'd12:   w_hdr_byte = 8'h04;
            default: w_hdr_byte = 8'h00;
        endcase
    end
`endif

    // Next state and stream outputs
    always_comb begin
        w_next     = r_state;
        w_done_set = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
`ifdef QOI_CTRL_HEADER_EN
                    w_next = c_HDR;
`else
                    if (w_n != 32'd0) w_next = c_PIX;
                    else              w_done_set = 1'b1;
`endif
                end
            end
`ifdef QOI_CTRL_HEADER_EN
            c_HDR: begin
                out_valid = 1'b1;
                out_data  = w_hdr_byte;
                if (out_ready && (r_idx == 4'd13))
                    w_next = (r_npix == 32'd0) ? c_TAIL : c_PIX;
            end
            c_TAIL: begin
                out_valid = 1'b1;
                out_data  = (r_idx == 4'd7) ? 8'h01 : 8'h00;
                out_last  = (r_idx == 4'd7);
                if (out_ready && (r_idx == 4'd7)) begin
                    w_next     = c_IDLE;
                    w_done_set = 1'b1;
                end
            end
`endif
            c_PIX: begin
                out_valid = w_ser_valid;
                out_data  = w_ser_valid ? r_ser_data[31:24] : 8'h00;
                if (w_consume && (r_npix == 32'd1)) w_next = c_FLUSH;
            end
            c_FLUSH: begin
                out_valid = w_ser_valid;
                out_data  = w_ser_valid ? r_ser_data[31:24] : 8'h00;
`ifndef QOI_CTRL_HEADER_EN
                // Final byte: no more chunks can arrive and nothing is queued.
                out_last  = w_ser_valid && r_flush_sent && !w_push &&
                            w_fifo_empty && (r_ser_cnt == 3'd1);
`endif
                if (r_flush_sent && !r_en_d && w_fifo_empty && (r_ser_cnt == 3'd0)) begin
`ifdef QOI_CTRL_HEADER_EN
                    w_next     = c_TAIL;
`else
                    w_next     = c_IDLE;
                    w_done_set = 1'b1;
`endif
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Encoder feed: live pixels in PIX; in FLUSH a copy of the last pixel
    // with alpha inverted, which differs from it and so ends any pending run.
    always_comb begin
        enc_r = 8'h00;
        enc_g = 8'h00;
        enc_b = 8'h00;
        enc_a = 8'h00;
        if (r_state == c_PIX) begin
            {enc_r, enc_g, enc_b, enc_a} = {px_r, px_g, px_b, px_a};
        end else if (r_state == c_FLUSH) begin
            {enc_r, enc_g, enc_b, enc_a} = {r_last_px[31:8], ~r_last_px[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wptr] <= {enc_chunk_bytes, enc_chunk};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_done       <= 1'b0;
            r_npix       <= 32'd0;
            r_last_px    <= 32'd0;
            r_first      <= 1'b0;
            r_en_d       <= 1'b0;
            r_en_first_d <= 1'b0;
            r_flush_sent <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_ser_data   <= 32'd0;
            r_ser_cnt    <= 3'd0;
`ifdef QOI_CTRL_HEADER_EN
            r_width      <= 16'd0;
            r_height     <= 16'd0;
            r_idx        <= 4'd0;
`endif
        end else begin
            r_state      <= w_next;
            r_done       <= w_done_set;
            r_en_d       <= enc_en;
            r_en_first_d <= enc_en && r_first;

            if (w_start) begin
                r_npix       <= w_n;
                r_first      <= 1'b1;
                r_flush_sent <= 1'b0;
`ifdef QOI_CTRL_HEADER_EN
                r_width      <= width;
                r_height     <= height;
`endif
            end else begin
                if (enc_en)     r_first      <= 1'b0;
                if (w_flush_en) r_flush_sent <= 1'b1;
                if (w_consume) begin
                    r_npix    <= r_npix - 32'd1;
                    r_last_px <= {px_r, px_g, px_b, px_a};
                end
            end

`ifdef QOI_CTRL_HEADER_EN
            if (w_start)
                r_idx <= 4'd0;
            else if (((r_state == c_HDR) || (r_state == c_TAIL)) && out_ready)
                r_idx <= (w_next != r_state) ? 4'd0 : r_idx + 4'd1;
`endif

            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pop) begin
                r_ser_data <= w_head[31:0];
                r_ser_cnt  <= w_head[34:32];
            end else if (w_ser_fire) begin
                r_ser_data <= {r_ser_data[23:0], 8'h00};
                r_ser_cnt  <= r_ser_cnt - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/qoi_frame_ctrl.md
QOI_FRAME_CTRL -- requirements
Module: qoi_frame_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, chunk FIFO entries (power of two, >=4).
REQ-002 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have start input 1 (frame request, IDLE only); width, height input 16 each (sampled when start accepted).
REQ-005 SHALL have busy output 1 (high outside IDLE) and done output 1 (one-cycle pulse after the last byte transfers).
REQ-006 SHALL have px_r, px_g, px_b, px_a input 8 each; px_valid input 1; px_ready output 1 (pixel source handshake).
REQ-007 SHALL have enc_r, enc_g, enc_b, enc_a output 8 each; enc_en output 1 (encoder advances one pixel on cycles where high); enc_rst output 1.
REQ-008 SHALL have enc_chunk input 32 (MSB-aligned chunk bytes) and enc_chunk_bytes input 3 (0..4, registered encoder outputs).
REQ-009 SHALL have out_data output 8, out_valid output 1, out_ready input 1, out_last output 1 (byte stream).

Function
REQ-010 SHALL use states IDLE, HDR, PIX, FLUSH, TAIL.
REQ-011 IDLE: start=1 -> latch width/height, load pixel counter N=width*height (32 bit), pulse enc_rst for one cycle, go HDR.
REQ-012 HDR SHALL emit 14 bytes: 71 6F 69 66, width as 32-bit big-endian, height as 32-bit big-endian, 04, 00; then go PIX.
REQ-013 PIX: px_ready=1 and enc_en=1 exactly when px_valid=1 and FIFO occupancy <= FIFO_DEPTH-2; enc_* = px_*; the pixel is consumed on that cycle.
REQ-014 Chunk capture: after enable k (k=0..N), enc_chunk/enc_chunk_bytes the following cycle belong to pixel k-1; SHALL push to FIFO for k=1..N only when enc_chunk_bytes != 0; output after enable 0 is discarded.
REQ-015 After N pixels consumed SHALL go FLUSH and issue one enable with enc_* = last pixel with alpha inverted (forces any pending run out); px_ready=0 in FLUSH.
REQ-016 FLUSH SHALL wait until the capture following the flush enable completes, then go TAIL once FIFO and serializer are empty.
REQ-017 N=0 (width or height 0) SHALL skip PIX/FLUSH: HDR -> TAIL, no enc_en.
REQ-018 Serializer SHALL pop one FIFO entry and emit enc_chunk_bytes bytes, MSB first, one per out_valid&out_ready cycle.
REQ-019 out_data/out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 TAIL SHALL emit 00 00 00 00 00 00 00 01; out_last=1 with the final 01; then done pulse, go IDLE.
REQ-021 FIFO push and pop in the same cycle SHALL both take effect; push when full SHALL not occur (guaranteed by REQ-013 margin).
REQ-022 start while busy SHALL be ignored.

Reset
REQ-023 rst=1 SHALL force IDLE, empty FIFO, clear counters; outputs busy=0, done=0, px_ready=0, enc_en=0, enc_rst=0, out_valid=0, out_last=0, out_data=0, enc_*=0.
REQ-024 rst mid-frame SHALL abandon the frame with no done pulse; the next start begins a fresh frame.

Configuration
REQ-025 Macro QOI_CTRL_HEADER_EN defined: HDR and TAIL as above.
REQ-026 QOI_CTRL_HEADER_EN undefined: HDR/TAIL bypassed, output is chunk bytes only, out_last marks the final byte of the final chunk; N=0 -> done pulse one cycle after start, no bytes.

Verification
REQ-027 start, width=1, height=1, pixel (00,00,00,FF), out_ready=1 -> header 71 6F 69 66 00 00 00 01 00 00 00 01 04 00, chunk bytes per encoder, then 7x00, 01 with out_last, done.
REQ-028 4x1 frame of identical pixels after first -> run chunk emitted during FLUSH (C2 for 3 repeats); no dummy-pixel chunk in stream.
REQ-029 width=0, height=5 -> 14 header bytes then 8 end bytes, enc_en never high.
REQ-030 64-pixel random frame, out_ready toggling 25% -> stream byte-identical to software reference, px_ready drops when FIFO reaches FIFO_DEPTH-1, no lost chunk.
REQ-031 rst asserted during PIX at pixel 10 -> all outputs at reset values next cycle, no done; new start produces a complete correct frame.
REQ-032 Build without QOI_CTRL_HEADER_EN, 2x1 frame -> first out byte is a chunk opcode, out_last on last chunk byte, no 0x01 terminator.
